// File: rtl/pipe_skid_buffer_pkg.sv
// Shared types and constants for the valid/ready pipeline stage with optional skid entry.
package pipe_skid_buffer_pkg;

  localparam int INSTR_W_DFLT = 16;
  localparam int PC_W_DFLT    = 32;
  localparam int OCC_W        = 2;

  typedef struct packed {
    logic [INSTR_W_DFLT-1:0] instr;
    logic [PC_W_DFLT-1:0]    pc;
    logic [PC_W_DFLT-1:0]    next_pc;
    logic                    bubble;
  } entry_t;

  // An empty slot reads as an all-zero NOP.
  localparam entry_t NOP_ENTRY = '0;

  function automatic logic [OCC_W-1:0] occ_count(input logic head_v, input logic skid_v);
    return {1'b0, head_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+valid register slot; clear (flush) dominates load, load dominates drop.
module pipe_entry_reg
  import pipe_skid_buffer_pkg::*;
#(
  parameter int W              = 8,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      if (CLEAR_ON_FLUSH != 0) data_d = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (drop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid, flush and bubble tagging.
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int INSTR_W        = 16,
  parameter int PC_W           = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_next_pc,
  input  logic               in_bubble,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_next_pc,
  output logic               out_bubble,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int ENTRY_W = INSTR_W + 2 * PC_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    next_pc;
    logic               bubble;
  } stage_entry_t;

  stage_entry_t       in_entry, head_entry;
  logic [ENTRY_W-1:0] head_data, skid_data, head_d_data;
  logic               head_valid, skid_valid;
  logic               head_load, head_drop, skid_load, skid_drop, head_from_skid;
  logic               accept, pop;

  assign in_entry = '{instr: in_instruction, pc: in_pc, next_pc: in_next_pc, bubble: in_bubble};
  assign accept   = in_valid & in_ready;
  assign pop      = head_valid & out_ready;

  // Head always holds the oldest entry; the skid only fills when head is stalled.
  always_comb begin
    head_load      = 1'b0;
    head_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    head_from_skid = 1'b0;
    if (pop) begin
      if (skid_valid) begin
        head_load      = 1'b1;
        head_from_skid = 1'b1;
        skid_drop      = 1'b1;
      end else if (accept) begin
        head_load = 1'b1;
      end else begin
        head_drop = 1'b1;
      end
    end else if (accept) begin
      if (head_valid) skid_load = 1'b1;
      else            head_load = 1'b1;
    end
  end

  assign head_d_data = head_from_skid ? skid_data : ENTRY_W'(in_entry);

  pipe_entry_reg #(.W(ENTRY_W), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .load  (head_load),
    .drop  (head_drop),
    .d     (head_d_data),
    .valid (head_valid),
    .q     (head_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.W(ENTRY_W), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     (ENTRY_W'(in_entry)),
        .valid (skid_valid),
        .q     (skid_data)
      );
      // Ready comes straight from a flop, so downstream stalls never reach upstream combinationally.
      assign in_ready = !skid_valid;
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign in_ready   = !head_valid | out_ready;
    end
  endgenerate

  assign head_entry      = stage_entry_t'(head_data);
  assign out_valid       = head_valid;
  assign out_instruction = head_valid ? head_entry.instr   : '0;
  assign out_pc          = head_valid ? head_entry.pc      : '0;
  assign out_next_pc     = head_valid ? head_entry.next_pc : '0;
  assign out_bubble      = head_valid ? head_entry.bubble  : 1'b1;
  assign occupancy       = occ_count(head_valid, skid_valid);

endmodule
